// File: rtl/pc_fetch.sv
// ============================================================================
//  pc_fetch : McCoy program counter and instruction-fetch sequencer.
//  Optional macro PC_SELF_LOOP_HALT_EN: a branch-to-self halts the core.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pc_fetch #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               fetchReq,
    output logic [PC_W-1:0]    fetchAddr,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic               instrValid,
    output logic [INSTR_W-1:0] instr,
    output logic               instrReady,
    input  logic               execDone,
    input  logic               pcSel,
    input  logic [PC_W-1:0]    aluOut,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    next_pc;

    // Offset is two's complement, so plain modular addition covers backward branches.
    always_comb begin
        next_pc = pcSel ? (pc_q + PC_W'(1)) : (pc_q + aluOut);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: begin
                if (instrValid) begin
                    instr_d = instrIn;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (execDone) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
`ifdef PC_SELF_LOOP_HALT_EN
                    if (!pcSel && (aluOut == '0)) begin
                        state_d = S_HALT;
                    end
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign fetchReq   = (state_q == S_FETCH);
    assign instrReady = (state_q == S_EXEC);
    assign fetchAddr  = pc_q;
    assign pc         = pc_q;
    assign instr      = instr_q;

`ifdef PC_SELF_LOOP_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
//  tb_pc_fetch : randomized and directed checks of pc_fetch against a
//  behavioural model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               fetchReq;
    logic [PC_W-1:0]    fetchAddr;
    logic [INSTR_W-1:0] instrIn;
    logic               instrValid;
    logic [INSTR_W-1:0] instr;
    logic               instrReady;
    logic               execDone;
    logic               pcSel;
    logic [PC_W-1:0]    aluOut;
    logic [PC_W-1:0]    pc;
    logic               halted;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model
    int m_pc;
    int m_instr;
    bit m_exec;
    bit m_halt;

    pc_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetchReq   (fetchReq),
        .fetchAddr  (fetchAddr),
        .instrIn    (instrIn),
        .instrValid (instrValid),
        .instr      (instr),
        .instrReady (instrReady),
        .execDone   (execDone),
        .pcSel      (pcSel),
        .aluOut     (aluOut),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_instr = 0;
        m_exec  = 0;
        m_halt  = 0;
    endtask

    task automatic model_edge(input bit iv, input int ii, input bit ed, input bit ps, input int ao);
        if (m_halt) return;
        if (!m_exec) begin
            if (iv) begin
                m_instr = ii;
                m_exec  = 1;
            end
        end else if (ed) begin
`ifdef PC_SELF_LOOP_HALT_EN
            if (!ps && ao == 0) m_halt = 1;
`endif
            m_pc   = ps ? (m_pc + 1) % 256 : (m_pc + ao) % 256;
            m_exec = 0;
        end
    endtask

    task automatic compare_all();
        check("fetchReq",   32'(fetchReq),   32'(!m_exec && !m_halt));
        check("instrReady", 32'(instrReady), 32'(m_exec));
        check("fetchAddr",  32'(fetchAddr),  32'(m_pc));
        check("pc",         32'(pc),         32'(m_pc));
        check("instr",      32'(instr),      32'(m_instr));
        check("halted",     32'(halted),     32'(m_halt));
    endtask

    task automatic step(input bit iv, input logic [7:0] ii, input bit ed, input bit ps, input logic [7:0] ao);
        @(negedge clk);
        instrValid = iv;
        instrIn    = ii;
        execDone   = ed;
        pcSel      = ps;
        aluOut     = ao;
        @(posedge clk);
        model_edge(iv, int'(ii), ed, ps, int'(ao));
        #1;
        compare_all();
    endtask

    // One full instruction at minimum period: fetch then execute.
    task automatic instr_cycle(input bit ps, input logic [7:0] ao);
        step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, ps, ao);
    endtask

    // Reset asserted alongside execDone and instrValid; async effect checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        execDone   = 1'b1;
        instrValid = 1'b1;
        model_reset();
        #1;
        check("rst_pc",         32'(pc),         32'd0);
        check("rst_fetchReq",   32'(fetchReq),   32'd1);
        check("rst_instrReady", 32'(instrReady), 32'd0);
        compare_all();
        @(negedge clk);
        reset      = 1'b0;
        execDone   = 1'b0;
        instrValid = 1'b0;
        #1;
        compare_all();
    endtask

    initial begin
        reset      = 1'b1;
        instrIn    = '0;
        instrValid = 1'b0;
        execDone   = 1'b0;
        pcSel      = 1'b0;
        aluOut     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", 32'(fetchAddr), 32'(i));
            instr_cycle(1'b1, 8'h00);
        end

        // Relative branches and wraps
        do_reset();
        instr_cycle(1'b0, 8'd5);
        check("at5", 32'(pc), 32'd5);
        instr_cycle(1'b0, 8'hFD);
        check("br_back", 32'(fetchAddr), 32'd2);
        instr_cycle(1'b0, 8'd248);
        check("at250", 32'(pc), 32'd250);
        instr_cycle(1'b0, 8'd10);
        check("br_wrap", 32'(fetchAddr), 32'd4);
        instr_cycle(1'b0, 8'd251);
        instr_cycle(1'b1, 8'h00);
        check("inc_wrap", 32'(pc), 32'd0);

        // Stall with stray execDone, then stray instrValid during EXEC
        for (int i = 0; i < 5; i++) step(1'b0, 8'($urandom), 1'(i % 2), 1'b1, 8'd3);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        check("stall_instr", 32'(instr), 32'hA5);
        step(1'b1, 8'h5A, 1'b0, 1'b1, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);

        // Reset in EXEC at pc=7 alongside execDone
        do_reset();
        instr_cycle(1'b0, 8'd7);
        step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
        do_reset();

        // Self-loop at pc=9
        instr_cycle(1'b0, 8'd9);
        instr_cycle(1'b0, 8'd0);
        check("self_pc", 32'(pc), 32'd9);
`ifdef PC_SELF_LOOP_HALT_EN
        check("self_halt", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b1, 1'b1, 8'h00);
        check("halt_pc", 32'(pc), 32'd9);
`else
        check("self_halt", 32'(halted), 32'd0);
        check("self_req", 32'(fetchReq), 32'd1);
`endif

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
